// File: rtl/full_handshake_rx_buf_pkg.sv
// Shared constants and helpers for the 4-phase handshake receive buffer.
// State encodings are one-hot and reused by the TX side of the link.
package full_handshake_rx_buf_pkg;

  typedef logic [1:0] fhs_state_t;

  localparam fhs_state_t FHS_STATE_IDLE = 2'b01;
  localparam fhs_state_t FHS_STATE_ACK  = 2'b10;

  // Occupancy counter needs one extra bit to represent DEPTH itself.
  function automatic int fhs_lw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/full_handshake_rx_buf_if.sv
// Bundle for the req/ack link on one side and the valid/ready consumer
// port on the other; the buffer itself uses the slave modport.
interface full_handshake_rx_buf_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
);
  import full_handshake_rx_buf_pkg::*;

  localparam int LW = fhs_lw(DEPTH);

  logic          req_i;
  logic [DW-1:0] req_data_i;
  logic          ack_o;
  logic [DW-1:0] recv_data_o;
  logic          recv_valid_o;
  logic          recv_ready_i;
  logic [LW-1:0] level_o;

  modport master (
    output req_i,
    output req_data_i,
    output recv_ready_i,
    input  ack_o,
    input  recv_data_o,
    input  recv_valid_o,
    input  level_o
  );

  modport slave (
    input  req_i,
    input  req_data_i,
    input  recv_ready_i,
    output ack_o,
    output recv_data_o,
    output recv_valid_o,
    output level_o
  );

endinterface

// File: rtl/full_handshake_rx_buf_sync.sv
// Reset-to-zero flop chain for bringing an asynchronous signal into clk.
// Reused by the TX side to synchronise ack.
module gen_sync_dff #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [STAGES-1:0][W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/full_handshake_rx_buf.sv
// Receive side of the 4-phase req/ack link: synchronises req, captures
// one word per req phase into a FIFO and withholds ack while it is full.
module full_handshake_rx_buf
  import full_handshake_rx_buf_pkg::*;
#(
  parameter int DW          = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  full_handshake_rx_buf_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = fhs_lw(DEPTH);

  logic          req_s;
  fhs_state_t    state_q, state_d;
  logic          ack_q, ack_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          full;
  logic          not_empty;
  logic          pop;

  gen_sync_dff #(
    .STAGES (SYNC_STAGES),
    .W      (1)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.req_i),
    .q_o (req_s)
  );

  assign full      = (lvl_q == LW'(DEPTH));
  assign not_empty = (lvl_q != '0);
  assign pop       = not_empty && bus.recv_ready_i;

  // The captured word is written one cycle after ack rises.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    wr_d    = 1'b0;
    wdat_d  = wdat_q;
    case (state_q)
      FHS_STATE_IDLE: begin
        if (req_s && !full) begin
          state_d = FHS_STATE_ACK;
          ack_d   = 1'b1;
          wr_d    = 1'b1;
          wdat_d  = bus.req_data_i;
        end
      end
      FHS_STATE_ACK: begin
        if (!req_s) begin
          state_d = FHS_STATE_IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = FHS_STATE_IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    wptr_d = wptr_q + AW'(wr_q);
    rptr_d = rptr_q + AW'(pop);
    lvl_d  = lvl_q + LW'(wr_q) - LW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FHS_STATE_IDLE;
      ack_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdat_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      wr_q    <= wr_d;
      wdat_q  <= wdat_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      lvl_q   <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_q) begin
      mem_q[wptr_q] <= wdat_q;
    end
  end

  // Storage is not reset; an empty FIFO presents zero instead.
  assign bus.ack_o        = ack_q;
  assign bus.recv_valid_o = not_empty;
  assign bus.recv_data_o  = not_empty ? mem_q[rptr_q] : '0;
  assign bus.level_o      = lvl_q;

endmodule

// File: tb/tb_full_handshake_rx_buf.sv
// Bench for full_handshake_rx_buf: three instances (DEPTH 4, 2, 8) checked
// every cycle against a queue model, plus directed literal checks.
module tb_full_handshake_rx_buf;

  localparam int NI = 3;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req    [NI];
  logic [31:0] dat    [NI];
  logic        rdy    [NI];
  logic        ack_w  [NI];
  logic        val_w  [NI];
  logic [31:0] data_w [NI];
  logic [7:0]  lvl_w  [NI];
  logic [31:0] sb     [NI][$];
  int          pops   [NI];
  int          base   [NI];
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          stop_rdy = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int g, input logic v, input int lim,
                          input string nm);
    int n;
    n = 0;
    while (ack_w[g] !== v && n < lim) begin
      tick();
      n++;
    end
    chk(nm, ack_w[g], v);
  endtask

  task automatic send(input int g, input logic [31:0] w, input int lim);
    sb[g].push_back(w);
    dat[g] = w;
    req[g] = 1'b1;
    wait_ack(g, 1'b1, lim, $sformatf("g%0d send ack rise", g));
    req[g] = 1'b0;
    wait_ack(g, 1'b0, lim, $sformatf("g%0d send ack fall", g));
  endtask

  task automatic pop1(input int g);
    rdy[g] = 1'b1;
    tick();
    rdy[g] = 1'b0;
  endtask

  task automatic rand_tx(input int g);
    for (int i = 1; i <= 1000; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(g, (g << 16) | i, 300);
    end
  endtask

  task automatic rdy_drv();
    while (!stop_rdy) begin
      tick();
      for (int g = 0; g < NI; g++) rdy[g] = 1'($urandom_range(0, 1));
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int D = (g == 0) ? 4 : ((g == 1) ? 2 : 8);

    full_handshake_rx_buf_if #(.DW(32), .DEPTH(D)) bus ();

    assign bus.req_i        = req[g];
    assign bus.req_data_i   = dat[g];
    assign bus.recv_ready_i = rdy[g];
    assign ack_w[g]         = bus.ack_o;
    assign val_w[g]         = bus.recv_valid_o;
    assign data_w[g]        = bus.recv_data_o;
    assign lvl_w[g]         = 8'(bus.level_o);

    full_handshake_rx_buf #(
      .DW          (32),
      .DEPTH       (D),
      .SYNC_STAGES (SS)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    // Model: req seen SS edges late; one word per req phase, stored the
    // edge after ack rises; no acceptance while D words are held.
    logic [31:0]   mq [$];
    logic          m_ack = 1'b0;
    logic          m_pend = 1'b0;
    logic [31:0]   m_pw = '0;
    logic [SS-1:0] m_h = '0;
    logic          m_rs;
    logic          m_full;

    initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_ack  = 1'b0;
        m_pend = 1'b0;
        m_h    = '0;
      end else begin
        m_rs   = m_h[SS-1];
        m_full = (mq.size() == D);
        m_h    = {m_h[SS-2:0], req[g]};
        if (mq.size() > 0 && rdy[g]) void'(mq.pop_front());
        if (m_pend) mq.push_back(m_pw);
        m_pend = 1'b0;
        if (m_ack) begin
          m_ack = m_rs;
        end else if (m_rs && !m_full) begin
          m_ack  = 1'b1;
          m_pend = 1'b1;
          m_pw   = dat[g];
        end
      end
    end

    logic p_ack = 1'b0;
    int   p_lvl = 0;

    initial forever begin
      @(negedge clk);
      if (!rst) begin
        chk($sformatf("g%0d ack", g), ack_w[g], m_ack);
        chk($sformatf("g%0d level", g), lvl_w[g], mq.size());
        chk($sformatf("g%0d valid", g), val_w[g], mq.size() > 0);
        if (mq.size() > 0) chk($sformatf("g%0d data", g), data_w[g], mq[0]);
        if (ack_w[g] && !p_ack)
          chk($sformatf("g%0d ack rose while full", g), p_lvl < D, 1);
        if (val_w[g] && rdy[g]) begin
          chk($sformatf("g%0d sb nonempty", g), sb[g].size() != 0, 1);
          if (sb[g].size() != 0)
            chk($sformatf("g%0d sb order", g), data_w[g], sb[g].pop_front());
          pops[g]++;
        end
        p_ack = ack_w[g];
        p_lvl = lvl_w[g];
      end else begin
        p_ack = 1'b0;
        p_lvl = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int g = 0; g < NI; g++) begin
      req[g]  = 1'b0;
      dat[g]  = '0;
      rdy[g]  = 1'b0;
      pops[g] = 0;
    end
    repeat (3) tick();
    chk("reset ack", ack_w[0], 1'b0);
    chk("reset valid", val_w[0], 1'b0);
    chk("reset level", lvl_w[0], 8'd0);
    chk("reset data", data_w[0], 32'h0);
    rst = 1'b0;
    tick();

    // 1: single transfer latency
    sb[0].push_back(32'hA5A5_0001);
    dat[0] = 32'hA5A5_0001;
    req[0] = 1'b1;
    repeat (2) tick();
    chk("t1 ack c2", ack_w[0], 1'b0);
    tick();
    chk("t1 ack c3", ack_w[0], 1'b1);
    chk("t1 valid c3", val_w[0], 1'b0);
    tick();
    chk("t1 valid c4", val_w[0], 1'b1);
    chk("t1 data c4", data_w[0], 32'hA5A5_0001);
    chk("t1 level c4", lvl_w[0], 8'd1);
    req[0] = 1'b0;
    repeat (2) tick();
    chk("t1 ack held", ack_w[0], 1'b1);
    tick();
    chk("t1 ack drop", ack_w[0], 1'b0);
    pop1(0);
    chk("t1 drained", lvl_w[0], 8'd0);

    // 2: burst against a stalled consumer
    for (int w = 1; w <= 4; w++) send(0, w, 20);
    chk("t2 level full", lvl_w[0], 8'd4);
    sb[0].push_back(32'd5);
    dat[0] = 32'd5;
    req[0] = 1'b1;
    repeat (10) tick();
    chk("t2 stall ack", ack_w[0], 1'b0);
    chk("t2 stall level", lvl_w[0], 8'd4);
    pop1(0);
    chk("t2 level after pop", lvl_w[0], 8'd3);
    chk("t2 head after pop", data_w[0], 32'd2);
    wait_ack(0, 1'b1, 10, "t2 word5 ack");
    req[0] = 1'b0;
    wait_ack(0, 1'b0, 10, "t2 word5 ack fall");
    chk("t2 level refilled", lvl_w[0], 8'd4);
    sb[0].push_back(32'd6);
    dat[0] = 32'd6;
    req[0] = 1'b1;
    repeat (5) tick();
    chk("t2 word6 stall", ack_w[0], 1'b0);
    fork
      begin
        wait_ack(0, 1'b1, 60, "t2 word6 ack");
        req[0] = 1'b0;
        wait_ack(0, 1'b0, 20, "t2 word6 ack fall");
      end
      begin
        for (int i = 2; i <= 6; i++) begin
          n = 0;
          while (!val_w[0] && n < 30) begin
            tick();
            n++;
          end
          chk("t2 drain valid", val_w[0], 1'b1);
          chk("t2 drain order", data_w[0], i);
          pop1(0);
        end
      end
    join
    chk("t2 empty", lvl_w[0], 8'd0);

    // 3: req held high captures once
    sb[0].push_back(32'h33);
    dat[0] = 32'h33;
    req[0] = 1'b1;
    repeat (20) tick();
    chk("t3 level", lvl_w[0], 8'd1);
    chk("t3 ack high", ack_w[0], 1'b1);
    req[0] = 1'b0;
    wait_ack(0, 1'b0, 5, "t3 ack fall");
    chk("t3 single push", lvl_w[0], 8'd1);
    pop1(0);
    chk("t3 drained", lvl_w[0], 8'd0);

    // 4: pop coincides with the store of a captured word
    send(0, 32'h41, 20);
    send(0, 32'h42, 20);
    sb[0].push_back(32'h43);
    dat[0] = 32'h43;
    req[0] = 1'b1;
    repeat (3) tick();
    chk("t4 ack", ack_w[0], 1'b1);
    pop1(0);
    chk("t4 level", lvl_w[0], 8'd2);
    chk("t4 head", data_w[0], 32'h42);
    req[0] = 1'b0;
    wait_ack(0, 1'b0, 10, "t4 ack fall");
    pop1(0);
    chk("t4 second", data_w[0], 32'h43);
    pop1(0);
    chk("t4 empty", lvl_w[0], 8'd0);

    // 5: reset in the middle of a handshake
    send(0, 32'h51, 20);
    send(0, 32'h52, 20);
    send(0, 32'h53, 20);
    chk("t5 level", lvl_w[0], 8'd3);
    sb[0].push_back(32'h54);
    dat[0] = 32'h54;
    req[0] = 1'b1;
    repeat (3) tick();
    chk("t5 mid ack", ack_w[0], 1'b1);
    #1;
    rst = 1'b1;
    for (int g = 0; g < NI; g++) sb[g].delete();
    #1;
    chk("t5 rst ack", ack_w[0], 1'b0);
    chk("t5 rst valid", val_w[0], 1'b0);
    chk("t5 rst level", lvl_w[0], 8'd0);
    chk("t5 rst data", data_w[0], 32'h0);
    req[0] = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    send(0, 32'hDEAD_BEEF, 20);
    chk("t5 new level", lvl_w[0], 8'd1);
    chk("t5 new data", data_w[0], 32'hDEAD_BEEF);
    pop1(0);
    chk("t5 empty", lvl_w[0], 8'd0);

    // 6: random timing on all three depths
    for (int g = 0; g < NI; g++) base[g] = pops[g];
    fork
      rdy_drv();
    join_none
    fork
      rand_tx(0);
      rand_tx(1);
      rand_tx(2);
    join
    stop_rdy = 1'b1;
    repeat (2) tick();
    for (int g = 0; g < NI; g++) rdy[g] = 1'b1;
    repeat (30) tick();
    for (int g = 0; g < NI; g++) rdy[g] = 1'b0;
    tick();
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("t6 g%0d pops", g), pops[g] - base[g], 1000);
      chk($sformatf("t6 g%0d sb left", g), sb[g].size(), 0);
      chk($sformatf("t6 g%0d level", g), lvl_w[g], 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
